ysyx_24110015_lsu_axi_gen2: RTL and testbench

//  Parametrised load/store unit between EXU and WBU; owns a single-outstanding AXI-lite master port.

---
 rtl/ysyx_24110015_lsu_pkg.sv | 41 ++++
 rtl/ysyx_24110015_lsu_lane.sv | 55 +++++
 rtl/ysyx_24110015_lsu_axi_gen2.sv | 184 ++++++++++++++++++
 tb/tb_ysyx_24110015_lsu_axi_gen2.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24110015_lsu_pkg.sv
// Shared types and helpers for the AXI-lite load/store unit.
package ysyx_24110015_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW_W,
    ST_B,
    ST_RESP
  } lsu_state_t;

  localparam logic [2:0] FUNC3_B  = 3'b000;
  localparam logic [2:0] FUNC3_H  = 3'b001;
  localparam logic [2:0] FUNC3_W  = 3'b010;
  localparam logic [2:0] FUNC3_D  = 3'b011;
  localparam logic [2:0] FUNC3_BU = 3'b100;
  localparam logic [2:0] FUNC3_HU = 3'b101;
  localparam logic [2:0] FUNC3_WU = 3'b110;
  localparam logic [2:0] FUNC3_RSV = 3'b111;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // log2 of the access size in bytes
  function automatic logic [1:0] size_of(input logic [2:0] func3);
    return func3[1:0];
  endfunction

  // low address bits that must be zero for a naturally aligned access
  function automatic logic [2:0] align_mask(input logic [2:0] func3);
    logic [2:0] m;
    case (size_of(func3))
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_24110015_lsu_lane.sv
// Byte-lane steering: load extract/extend and store data/strobe placement.
module ysyx_24110015_lsu_lane
  import ysyx_24110015_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W = $clog2(STRB_W)
) (
  input  logic [2:0]        func3,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [STRB_W-1:0] bus_wstrb
);

  logic [DATA_W-1:0] shifted;
  logic [7:0] mask8;

  assign shifted = bus_rdata >> {off, 3'b000};

  always_comb begin
    load_data = shifted;
    case (size_of(func3))
      2'd0: begin
        if (func3[2]) load_data = DATA_W'(shifted[7:0]);
        else          load_data = DATA_W'($signed(shifted[7:0]));
      end
      2'd1: begin
        if (func3[2]) load_data = DATA_W'(shifted[15:0]);
        else          load_data = DATA_W'($signed(shifted[15:0]));
      end
      2'd2: begin
        if (func3[2]) load_data = DATA_W'(shifted[31:0]);
        else          load_data = DATA_W'($signed(shifted[31:0]));
      end
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    mask8 = 8'h01;
    case (size_of(func3))
      2'd0:    mask8 = 8'h01;
      2'd1:    mask8 = 8'h03;
      2'd2:    mask8 = 8'h0f;
      default: mask8 = 8'hff;
    endcase
  end

  assign bus_wdata = store_data << {off, 3'b000};
  assign bus_wstrb = STRB_W'(mask8) << off;

endmodule

// File: rtl/ysyx_24110015_lsu_axi_gen2.sv
// Single-outstanding AXI-lite load/store unit: request latch, FSM, address/size
// selection and response registers.
module ysyx_24110015_lsu_axi_gen2
  import ysyx_24110015_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] WIDE_BASE = 32'h0f000000,
  parameter logic [ADDR_W-1:0] WIDE_MASK = 32'hff000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_func3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                resp_misalign,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arsize,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awsize,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W = $clog2(STRB_W);

  lsu_state_t state_reg, state_next;

  logic              we_reg;
  logic [2:0]        func3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              aw_done_reg, w_done_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg, misalign_reg;

  logic              accept, req_misalign, req_illegal, wide_hit;
  logic [ADDR_W-1:0] bus_addr;
  logic [2:0]        bus_size;
  logic [DATA_W-1:0] load_data;

  assign accept = req_valid && req_ready;
  assign req_misalign = (req_addr[2:0] & align_mask(req_func3)) != 3'b000;
  assign req_illegal = (req_func3 == FUNC3_RSV)
                    || ((DATA_W == 32) && (req_func3 == FUNC3_D || req_func3 == FUNC3_WU))
                    || (req_we && req_func3[2]);

  // Full-word region: bus sees a whole aligned beat, lanes still pick the bytes.
  assign wide_hit = (addr_reg & WIDE_MASK) == WIDE_BASE;
  assign bus_addr = wide_hit ? (addr_reg & ~ADDR_W'(STRB_W - 1)) : addr_reg;
  assign bus_size = wide_hit ? 3'(OFF_W) : {1'b0, size_of(func3_reg)};

  assign m_araddr = bus_addr;
  assign m_arsize = bus_size;
  assign m_awaddr = bus_addr;
  assign m_awsize = bus_size;

  ysyx_24110015_lsu_lane #(.DATA_W(DATA_W)) u_lane (
    .func3      (func3_reg),
    .off        (addr_reg[OFF_W-1:0]),
    .bus_rdata  (m_rdata),
    .store_data (wdata_reg),
    .load_data  (load_data),
    .bus_wdata  (m_wdata),
    .bus_wstrb  (m_wstrb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_misalign || req_illegal) state_next = ST_RESP;
          else if (req_we)                 state_next = ST_AW_W;
          else                             state_next = ST_AR;
        end
      end
      ST_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_next = ST_R;
      end
      ST_R: begin
        m_rready = 1'b1;
        if (m_rvalid) state_next = ST_RESP;
      end
      ST_AW_W: begin
        m_awvalid = !aw_done_reg;
        m_wvalid  = !w_done_reg;
        if ((aw_done_reg || m_awready) && (w_done_reg || m_wready)) state_next = ST_B;
      end
      ST_B: begin
        m_bready = 1'b1;
        if (m_bvalid) state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg       <= 1'b0;
      func3_reg    <= 3'b000;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            we_reg       <= req_we;
            func3_reg    <= req_func3;
            addr_reg     <= req_addr;
            wdata_reg    <= req_wdata;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            rdata_reg    <= '0;
            err_reg      <= !req_misalign && req_illegal;
            misalign_reg <= req_misalign;
          end
        end
        ST_R: begin
          if (m_rvalid) begin
            if (m_rresp == AXI_RESP_OKAY) rdata_reg <= load_data;
            else                          err_reg   <= 1'b1;
          end
        end
        ST_AW_W: begin
          if (m_awready) aw_done_reg <= 1'b1;
          if (m_wready)  w_done_reg  <= 1'b1;
        end
        ST_B: begin
          if (m_bvalid && m_bresp != AXI_RESP_OKAY) err_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata    = we_reg ? '0 : rdata_reg;
  assign resp_err      = err_reg;
  assign resp_misalign = misalign_reg;

endmodule

// File: tb/tb_ysyx_24110015_lsu_axi_gen2.sv
// Randomized bench for the LSU: a 32-bit instance driven by a scripted AXI slave
// and checked against a behavioural model, plus a 64-bit instance with directed loads/stores.
module tb_ysyx_24110015_lsu_axi_gen2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, resp_misalign;
  logic [31:0] resp_rdata;
  logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic [2:0]  m_arsize, m_awsize;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]  m_rresp, m_bresp;
  logic [3:0]  m_wstrb;

  ysyx_24110015_lsu_axi_gen2 #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_misalign(resp_misalign),
    .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awsize(m_awsize), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  // 64-bit instance with an always-ready OKAY slave
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [2:0]  d_req_func3;
  logic [31:0] d_req_addr;
  logic [63:0] d_req_wdata, d_resp_rdata;
  logic        d_resp_valid, d_resp_err, d_resp_misalign;
  logic [31:0] d_araddr, d_awaddr;
  logic [2:0]  d_arsize, d_awsize;
  logic        d_arvalid, d_rready, d_awvalid, d_wvalid, d_bready;
  logic [63:0] d_wdata;
  logic [7:0]  d_wstrb;
  logic [63:0] d_rdata = 64'h0123456789abcdef;
  logic        d_one = 1'b1;
  logic [1:0]  d_okay = 2'b00;

  ysyx_24110015_lsu_axi_gen2 #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(d_req_we),
    .req_func3(d_req_func3), .req_addr(d_req_addr), .req_wdata(d_req_wdata),
    .resp_valid(d_resp_valid), .resp_rdata(d_resp_rdata), .resp_err(d_resp_err),
    .resp_misalign(d_resp_misalign),
    .m_araddr(d_araddr), .m_arsize(d_arsize), .m_arvalid(d_arvalid), .m_arready(d_one),
    .m_rdata(d_rdata), .m_rresp(d_okay), .m_rvalid(d_one), .m_rready(d_rready),
    .m_awaddr(d_awaddr), .m_awsize(d_awsize), .m_awvalid(d_awvalid), .m_awready(d_one),
    .m_wdata(d_wdata), .m_wstrb(d_wstrb), .m_wvalid(d_wvalid), .m_wready(d_one),
    .m_bresp(d_okay), .m_bvalid(d_one), .m_bready(d_bready)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model (32-bit bus) ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_misalign(input logic [31:0] addr, input logic [2:0] f3);
    return (addr % nbytes(f3)) != 0;
  endfunction

  function automatic bit model_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'd7) || (f3 == 3'd3) || (f3 == 3'd6) || (we && f3 >= 3'd4);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int off = addr % 4;
    int nb = nbytes(f3);
    logic [63:0] mask = (64'd1 << (8 * nb)) - 64'd1;
    logic [63:0] v = ({32'd0, rdata} >> (8 * off)) & mask;
    if (!f3[2] && v[8 * nb - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  int busy_ready_cnt;

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [1:0] rresp, input logic [1:0] bresp,
                         input int arw, input int rw, input int aww, input int ww, input int bw);
    bit exp_mis, exp_ill, fault, wide, exp_err;
    logic [31:0] exp_addr, exp_rdata, exp_wdata;
    logic [2:0] exp_size;
    logic [3:0] exp_strb;
    int exp_lat, off;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int ar_hs = 0, aw_hs = 0, w_hs = 0, resp_cnt = 0, resp_k = 0, stable_viol = 0;
    bit bus_any = 0, ar_pend = 0, aw_pend = 0, w_pend = 0;
    logic [31:0] g_addr = 0, g_wdata = 0, g_rdata = 0, p_ar = 0, p_aw = 0, p_wd = 0;
    logic [2:0] g_size = 0, p_ars = 0, p_aws = 0;
    logic [3:0] g_strb = 0, p_ws = 0;
    logic g_err = 0, g_mis = 0;

    exp_mis = model_misalign(addr, f3);
    exp_ill = !exp_mis && model_illegal(we, f3);
    fault = exp_mis || exp_ill;
    wide = (addr & 32'hff000000) == 32'h0f000000;
    exp_addr = wide ? (addr & ~32'd3) : addr;
    exp_size = wide ? 3'd2 : {1'b0, f3[1:0]};
    off = addr % 4;
    exp_wdata = wdata << (8 * off);
    exp_strb = 4'(((1 << nbytes(f3)) - 1) << off);
    if (fault) exp_lat = 1;
    else if (we) exp_lat = 3 + ((aww > ww) ? aww : ww) + bw;
    else exp_lat = 3 + arw + rw;
    exp_err = exp_ill || (!fault && (we ? (bresp != 2'b00) : (rresp != 2'b00)));
    exp_rdata = (fault || we || rresp != 2'b00) ? 32'd0 : model_load(f3, addr, rdata);

    check_eq("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    // keep offering junk while busy; it must be ignored
    req_we = 1'($urandom); req_func3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;

    for (int k = 1; k <= 60; k++) begin
      if (resp_cnt > 0) begin
        check_eq("no_second_resp", resp_valid, 1'b0);
        break;
      end
      if (req_ready) busy_ready_cnt++;
      if (m_arvalid || m_awvalid || m_wvalid || m_rready || m_bready) bus_any = 1;
      if (ar_pend && !(m_arvalid && m_araddr == p_ar && m_arsize == p_ars)) stable_viol++;
      if (aw_pend && !(m_awvalid && m_awaddr == p_aw && m_awsize == p_aws)) stable_viol++;
      if (w_pend && !(m_wvalid && m_wdata == p_wd && m_wstrb == p_ws)) stable_viol++;

      m_arready = m_arvalid && (ar_cnt >= arw);
      if (m_arvalid) ar_cnt++;
      if (m_arready) begin ar_hs++; g_addr = m_araddr; g_size = m_arsize; end
      ar_pend = m_arvalid && !m_arready; p_ar = m_araddr; p_ars = m_arsize;

      m_rvalid = m_rready && (r_cnt >= rw);
      if (m_rready) r_cnt++;
      m_rdata = m_rvalid ? rdata : $urandom;
      m_rresp = m_rvalid ? rresp : 2'($urandom);

      m_awready = m_awvalid && (aw_cnt >= aww);
      if (m_awvalid) aw_cnt++;
      if (m_awready) begin aw_hs++; g_addr = m_awaddr; g_size = m_awsize; end
      aw_pend = m_awvalid && !m_awready; p_aw = m_awaddr; p_aws = m_awsize;

      m_wready = m_wvalid && (w_cnt >= ww);
      if (m_wvalid) w_cnt++;
      if (m_wready) begin w_hs++; g_wdata = m_wdata; g_strb = m_wstrb; end
      w_pend = m_wvalid && !m_wready; p_wd = m_wdata; p_ws = m_wstrb;

      m_bvalid = m_bready && (b_cnt >= bw);
      if (m_bready) b_cnt++;
      m_bresp = m_bvalid ? bresp : 2'($urandom);

      if (resp_valid) begin
        resp_cnt++; resp_k = k;
        g_rdata = resp_rdata; g_err = resp_err; g_mis = resp_misalign;
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;

    check_eq("resp_count", resp_cnt, 1);
    check_eq("latency", resp_k, exp_lat);
    check_eq("resp_misalign", g_mis, exp_mis);
    check_eq("resp_err", g_err, exp_err);
    check_eq("resp_rdata", g_rdata, exp_rdata);
    check_eq("stable_while_stalled", stable_viol, 0);
    if (fault) begin
      check_eq("no_bus_on_fault", bus_any, 1'b0);
    end else if (!we) begin
      check_eq("ar_handshakes", ar_hs, 1);
      check_eq("no_write_channel", aw_hs + w_hs, 0);
      check_eq("araddr", g_addr, exp_addr);
      check_eq("arsize", g_size, exp_size);
    end else begin
      check_eq("aw_w_handshakes", {aw_hs[7:0], w_hs[7:0], ar_hs[7:0]}, {8'd1, 8'd1, 8'd0});
      check_eq("awaddr", g_addr, exp_addr);
      check_eq("awsize", g_size, exp_size);
      check_eq("wdata", g_wdata, exp_wdata);
      check_eq("wstrb", g_strb, exp_strb);
    end
    $display("txn we=%0d f3=%0d addr=%h lat=%0d rdata=%h err=%0d mis=%0d",
             we, f3, addr, resp_k, g_rdata, g_err, g_mis);
  endtask

  task automatic run64(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] wdata, input logic [31:0] exp_addr,
                       input logic [2:0] exp_size, input logic [63:0] exp_data,
                       input logic [7:0] exp_strb);
    logic [31:0] g_addr = 0;
    logic [2:0] g_size = 0;
    logic [63:0] g_data = 0;
    logic [7:0] g_strb = 0;
    logic g_err = 1'b1;
    int lat = 0;
    d_req_valid = 1'b1; d_req_we = we; d_req_func3 = f3; d_req_addr = addr; d_req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    d_req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (d_arvalid) begin g_addr = d_araddr; g_size = d_arsize; end
      if (d_awvalid) begin g_addr = d_awaddr; g_size = d_awsize; end
      if (d_wvalid) begin g_data = d_wdata; g_strb = d_wstrb; end
      if (d_resp_valid) begin
        lat = k; g_err = d_resp_err;
        if (!we) g_data = d_resp_rdata;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    check_eq("w64_latency", lat, 3);
    check_eq("w64_err", g_err, 1'b0);
    check_eq("w64_addr", g_addr, exp_addr);
    check_eq("w64_size", g_size, exp_size);
    check_eq("w64_data", g_data, exp_data);
    if (we) check_eq("w64_wstrb", g_strb, exp_strb);
    $display("txn64 we=%0d f3=%0d addr=%h lat=%0d data=%h", we, f3, addr, lat, g_data);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic we;
    logic [2:0] f3;
    logic [31:0] base, addr;
    logic [1:0] rr, br;
    int rst_resp;

    rst = 1'b1;
    busy_ready_cnt = 0;
    req_valid = 0; req_we = 0; req_func3 = 0; req_addr = 0; req_wdata = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    d_req_valid = 0; d_req_we = 0; d_req_func3 = 0; d_req_addr = 0; d_req_wdata = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1'b1);
    check_eq("rst_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 5'b0);
    check_eq("rst_resp", {resp_valid, resp_err, resp_misalign}, 3'b0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);
    check_eq("rst_req_ready64", d_req_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b0, 3'b010, 32'h80000004, 32'h0, 32'hdeadbeef, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    run_txn(1'b0, 3'b000, 32'h0f000003, 32'h0, 32'h80112233, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    run_txn(1'b1, 3'b001, 32'h10000002, 32'h00001234, 32'h0, 2'b00, 2'b00, 0, 0, 0, 2, 0);
    run_txn(1'b0, 3'b010, 32'h80000002, 32'h0, 32'h12345678, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    run_txn(1'b0, 3'b010, 32'h80000010, 32'h0, 32'h55aa55aa, 2'b10, 2'b00, 1, 1, 0, 0, 0);
    run_txn(1'b1, 3'b010, 32'h80000020, 32'hcafef00d, 32'h0, 2'b00, 2'b00, 0, 0, 2, 0, 1);
    run_txn(1'b0, 3'b111, 32'h80000000, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    run_txn(1'b1, 3'b100, 32'h80000000, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    run_txn(1'b1, 3'b000, 32'h10000003, 32'h000000a5, 32'h0, 2'b00, 2'b11, 0, 0, 1, 1, 2);
    run_txn(1'b0, 3'b101, 32'h0f00000e, 32'h0, 32'hbeef1234, 2'b00, 2'b00, 3, 2, 0, 0, 0);

    // reset while the write address/data channels are waiting
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010; req_addr = 32'h10000000; req_wdata = 32'h1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("aw_w_entered", {m_awvalid, m_wvalid}, 2'b11);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_valids", {m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready}, 5'b0);
    check_eq("rst_mid_req_ready", req_ready, 1'b1);
    check_eq("rst_mid_resp", resp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rst_resp = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) rst_resp++;
      @(negedge clk);
    end
    check_eq("rst_mid_no_resp", rst_resp, 0);
    $display("txn reset-in-aw_w done");

    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      case ($urandom % 3)
        0: base = 32'h80000000;
        1: base = 32'h0f000100;
        default: base = 32'h10000000;
      endcase
      addr = base + ($urandom % 16);
      rr = ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      br = ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(we, f3, addr, $urandom, $urandom, rr, br,
              $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 4);
    end
    check_eq("req_ready_low_while_busy", busy_ready_cnt, 0);

    run64(1'b0, 3'b011, 32'h80000008, 64'h0, 32'h80000008, 3'd3, 64'h0123456789abcdef, 8'h00);
    run64(1'b0, 3'b110, 32'h80000004, 64'h0, 32'h80000004, 3'd2, 64'h0000000001234567, 8'h00);
    run64(1'b0, 3'b001, 32'h80000002, 64'h0, 32'h80000002, 3'd1, 64'hffffffffffff89ab, 8'h00);
    run64(1'b0, 3'b000, 32'h0f000005, 64'h0, 32'h0f000000, 3'd3, 64'h0000000000000045, 8'h00);
    run64(1'b1, 3'b010, 32'h80000004, 64'h00000000cafef00d, 32'h80000004, 3'd2,
          64'hcafef00d00000000, 8'hf0);
    run64(1'b1, 3'b011, 32'h0f000010, 64'h1122334455667788, 32'h0f000010, 3'd3,
          64'h1122334455667788, 8'hff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
